// File: rtl/exec_pkg.sv
// Shared types and constants for the 3-lane execute stage.
package exec_pkg;

    localparam int unsigned WIDTH  = 16;
    localparam int unsigned LANES  = 3;
    localparam int unsigned CNT_W  = $clog2(WIDTH);

    localparam int unsigned FLAG_N = 3;
    localparam int unsigned FLAG_Z = 2;
    localparam int unsigned FLAG_C = 1;
    localparam int unsigned FLAG_V = 0;

    typedef enum logic [3:0] {
        OP_ADD  = 4'b0000,
        OP_SUB  = 4'b0001,
        OP_AND  = 4'b0010,
        OP_OR   = 4'b0011,
        OP_XOR  = 4'b0100,
        OP_SHL  = 4'b0101,
        OP_SHR  = 4'b0110,
        OP_MUL  = 4'b0111,
        OP_MOVB = 4'b1000
    } alu_op_e;

    typedef enum logic {
        IDLE = 1'b0,
        MUL  = 1'b1
    } exec_state_e;

    typedef struct packed {
        logic pc_src;
        logic reg_write;
        logic mem_to_reg;
        logic mem_write;
        logic branch;
    } ctrl_t;

    typedef logic [LANES-1:0][WIDTH-1:0] vec_t;

    // NZCV nibble from one lane's result and its carry/overflow.
    function automatic logic [3:0] make_flags(input logic [WIDTH-1:0] res,
                                              input logic c, input logic v);
        logic [3:0] f;
        f         = '0;
        f[FLAG_N] = res[WIDTH-1];
        f[FLAG_Z] = (res == '0);
        f[FLAG_C] = c;
        f[FLAG_V] = v;
        return f;
    endfunction

endpackage

// File: rtl/lane_alu.sv
// Combinational single-lane ALU; MUL is handled by the stage FSM and yields 0 here.
module lane_alu
    import exec_pkg::*;
(
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  alu_op_e          op,
    output logic [WIDTH-1:0] res,
    output logic             carry,
    output logic             overflow
);

    logic [WIDTH:0] sum;
    logic [WIDTH:0] diff;

    assign sum  = {1'b0, a} + {1'b0, b};
    assign diff = {1'b0, a} - {1'b0, b};

    always_comb begin
        res      = '0;
        carry    = 1'b0;
        overflow = 1'b0;
        case (op)
            OP_ADD: begin
                res      = sum[WIDTH-1:0];
                carry    = sum[WIDTH];
                overflow = (a[WIDTH-1] == b[WIDTH-1]) && (res[WIDTH-1] != a[WIDTH-1]);
            end
            OP_SUB: begin
                res      = diff[WIDTH-1:0];
                carry    = ~diff[WIDTH];
                overflow = (a[WIDTH-1] != b[WIDTH-1]) && (res[WIDTH-1] != a[WIDTH-1]);
            end
            OP_AND:  res = a & b;
            OP_OR:   res = a | b;
            OP_XOR:  res = a ^ b;
            OP_SHL:  res = a << b[3:0];
            OP_SHR:  res = a >> b[3:0];
            OP_MOVB: res = b;
            default: res = '0;
        endcase
    end

endmodule

// File: rtl/execute_stage.sv
// EX stage: operand-B mux, lane ALUs, NZCV register and EX/MEM output registers.
// EXEC_MUL_EN enables the multi-cycle shift-add multiply FSM; otherwise MUL is an undefined op.
module execute_stage
    import exec_pkg::*;
(
    input  logic                        clk,
    input  logic                        reset,
    input  logic                        flush,
    input  logic                        valid_in,
    input  logic [LANES-1:0][WIDTH-1:0] opa,
    input  logic [LANES-1:0][WIDTH-1:0] opb,
    input  logic [LANES-1:0][WIDTH-1:0] imm,
    input  logic [3:0]                  alu_ctrl,
    input  logic                        alu_src,
    input  logic                        flag_write,
    input  logic                        pc_src,
    input  logic                        reg_write,
    input  logic                        mem_to_reg,
    input  logic                        mem_write,
    input  logic                        branch,
    output logic [LANES-1:0][WIDTH-1:0] result,
    output logic [LANES-1:0][WIDTH-1:0] store_data,
    output logic                        pc_src_o,
    output logic                        reg_write_o,
    output logic                        mem_to_reg_o,
    output logic                        mem_write_o,
    output logic                        branch_o,
    output logic                        valid_out,
    output logic [3:0]                  flags,
    output logic                        stall
);

    alu_op_e    op;
    vec_t       opb_sel;
    vec_t       alu_res;
    logic [LANES-1:0] alu_c;
    logic [LANES-1:0] alu_v;
    ctrl_t      ctrl_in;
    ctrl_t      ctrl_q;
    logic       unused_lane_flags;

    assign op      = alu_op_e'(alu_ctrl);
    assign opb_sel = alu_src ? imm : opb;
    assign ctrl_in = {pc_src, reg_write, mem_to_reg, mem_write, branch};

    for (genvar i = 0; i < LANES; i++) begin : g_lane
        lane_alu u_alu (
            .a        (opa[i]),
            .b        (opb_sel[i]),
            .op       (op),
            .res      (alu_res[i]),
            .carry    (alu_c[i]),
            .overflow (alu_v[i])
        );
    end

    // Only lane 0 drives the flags.
    assign unused_lane_flags = ^{alu_c[LANES-1:1], alu_v[LANES-1:1]};

    assign pc_src_o     = ctrl_q.pc_src;
    assign reg_write_o  = ctrl_q.reg_write;
    assign mem_to_reg_o = ctrl_q.mem_to_reg;
    assign mem_write_o  = ctrl_q.mem_write;
    assign branch_o     = ctrl_q.branch;

`ifdef EXEC_MUL_EN
    exec_state_e      state;
    logic [CNT_W-1:0] cnt;
    logic             stall_q;
    vec_t             mul_a, mul_b, mul_acc, mul_store;
    vec_t             mul_a_nxt, mul_b_nxt, mul_acc_nxt;
    ctrl_t            mul_ctrl;
    logic             mul_fw;

    assign stall = stall_q;

    // One shift-add step per lane: accumulate, shift multiplicand up, multiplier down.
    always_comb begin
        mul_a_nxt   = mul_a;
        mul_b_nxt   = mul_b;
        mul_acc_nxt = mul_acc;
        for (int i = 0; i < LANES; i++) begin
            mul_acc_nxt[i] = mul_acc[i] + (mul_b[i][0] ? mul_a[i] : '0);
            mul_a_nxt[i]   = mul_a[i] << 1;
            mul_b_nxt[i]   = mul_b[i] >> 1;
        end
    end
`else
    assign stall = 1'b0;
`endif

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            result     <= '0;
            store_data <= '0;
            ctrl_q     <= '0;
            valid_out  <= 1'b0;
            flags      <= '0;
`ifdef EXEC_MUL_EN
            state      <= IDLE;
            stall_q    <= 1'b0;
            cnt        <= '0;
            mul_a      <= '0;
            mul_b      <= '0;
            mul_acc    <= '0;
            mul_store  <= '0;
            mul_ctrl   <= '0;
            mul_fw     <= 1'b0;
`endif
        end else if (flush) begin
            valid_out <= 1'b0;
`ifdef EXEC_MUL_EN
            state     <= IDLE;
            stall_q   <= 1'b0;
            cnt       <= '0;
`endif
        end
`ifdef EXEC_MUL_EN
        else if (state == MUL) begin
            mul_a   <= mul_a_nxt;
            mul_b   <= mul_b_nxt;
            mul_acc <= mul_acc_nxt;
            cnt     <= cnt + 1'b1;
            if (cnt == CNT_W'(WIDTH - 1)) begin
                result     <= mul_acc_nxt;
                store_data <= mul_store;
                ctrl_q     <= mul_ctrl;
                valid_out  <= 1'b1;
                if (mul_fw) flags <= make_flags(mul_acc_nxt[0], 1'b0, 1'b0);
                state      <= IDLE;
                stall_q    <= 1'b0;
            end
        end else if (valid_in && (op == OP_MUL)) begin
            mul_a     <= opa;
            mul_b     <= opb_sel;
            mul_acc   <= '0;
            mul_store <= opb;
            mul_ctrl  <= ctrl_in;
            mul_fw    <= flag_write;
            cnt       <= '0;
            valid_out <= 1'b0;
            state     <= MUL;
            stall_q   <= 1'b1;
        end
`endif
        else if (valid_in) begin
            result     <= alu_res;
            store_data <= opb;
            ctrl_q     <= ctrl_in;
            valid_out  <= 1'b1;
            if (flag_write) flags <= make_flags(alu_res[0], alu_c[0], alu_v[0]);
        end else begin
            valid_out <= 1'b0;
        end
    end

endmodule

// File: tb/tb_execute_stage.sv
// Directed bench for execute_stage; MUL sequences run only when EXEC_MUL_EN is defined.
`timescale 1ns/1ps
module tb_execute_stage;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        flush = 1'b0;
    logic        valid_in = 1'b0;
    logic [47:0] opa = '0, opb = '0, imm = '0;
    logic [3:0]  alu_ctrl = '0;
    logic        alu_src = 1'b0, flag_write = 1'b0;
    logic        pc_src = 1'b0, reg_write = 1'b0, mem_to_reg = 1'b0, mem_write = 1'b0, branch = 1'b0;
    logic [47:0] result, store_data;
    logic        pc_src_o, reg_write_o, mem_to_reg_o, mem_write_o, branch_o;
    logic        valid_out, stall;
    logic [3:0]  flags;

    int total = 0;
    int bad   = 0;

    execute_stage dut (
        .clk(clk), .reset(reset), .flush(flush), .valid_in(valid_in),
        .opa(opa), .opb(opb), .imm(imm), .alu_ctrl(alu_ctrl),
        .alu_src(alu_src), .flag_write(flag_write),
        .pc_src(pc_src), .reg_write(reg_write), .mem_to_reg(mem_to_reg),
        .mem_write(mem_write), .branch(branch),
        .result(result), .store_data(store_data),
        .pc_src_o(pc_src_o), .reg_write_o(reg_write_o), .mem_to_reg_o(mem_to_reg_o),
        .mem_write_o(mem_write_o), .branch_o(branch_o),
        .valid_out(valid_out), .flags(flags), .stall(stall)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic issue(input logic [3:0] op, input logic src, input logic fw,
                         input logic [47:0] a, input logic [47:0] b, input logic [47:0] i,
                         input logic [4:0] c);
        alu_ctrl = op; alu_src = src; flag_write = fw;
        opa = a; opb = b; imm = i;
        {pc_src, reg_write, mem_to_reg, mem_write, branch} = c;
        valid_in = 1'b1;
        tick();
    endtask

    task automatic expect_out(input string tag, input logic [47:0] r, input logic [47:0] sd,
                              input logic [4:0] c, input logic v, input logic [3:0] f);
        check({tag, ".result"}, 64'(result), 64'(r));
        check({tag, ".store"},  64'(store_data), 64'(sd));
        check({tag, ".ctrl"},   64'({pc_src_o, reg_write_o, mem_to_reg_o, mem_write_o, branch_o}), 64'(c));
        check({tag, ".valid"},  64'(valid_out), 64'(v));
        check({tag, ".flags"},  64'(flags), 64'(f));
    endtask

    logic [3:0]  t_op [8];
    logic [47:0] t_a  [8];
    logic [47:0] t_b  [8];
    logic [47:0] t_r  [8];
    logic [3:0]  t_f  [8];

    initial begin
        t_op[0] = 4'b0010; t_a[0] = {16'hFF00, 16'h0F0F, 16'hF0F0}; t_b[0] = {16'h0FF0, 16'hFFFF, 16'h0F0F};
        t_r[0] = {16'h0F00, 16'h0F0F, 16'h0000}; t_f[0] = 4'b0100;
        t_op[1] = 4'b0011; t_a[1] = t_a[0]; t_b[1] = t_b[0];
        t_r[1] = {16'hFFF0, 16'hFFFF, 16'hFFFF}; t_f[1] = 4'b1000;
        t_op[2] = 4'b0100; t_a[2] = t_a[0]; t_b[2] = t_b[0];
        t_r[2] = {16'hF0F0, 16'hF0F0, 16'hFFFF}; t_f[2] = 4'b1000;
        t_op[3] = 4'b0101; t_a[3] = {16'h0001, 16'h8001, 16'h00FF}; t_b[3] = {16'h0004, 16'h0011, 16'h000F};
        t_r[3] = {16'h0010, 16'h0002, 16'h8000}; t_f[3] = 4'b1000;
        t_op[4] = 4'b0110; t_a[4] = {16'h8000, 16'hFFFF, 16'h8000}; t_b[4] = {16'h000F, 16'h0004, 16'h0010};
        t_r[4] = {16'h0001, 16'h0FFF, 16'h8000}; t_f[4] = 4'b1000;
        t_op[5] = 4'b1000; t_a[5] = {16'h1111, 16'h2222, 16'h3333}; t_b[5] = {16'h1234, 16'h0000, 16'hABCD};
        t_r[5] = t_b[5]; t_f[5] = 4'b1000;
        t_op[6] = 4'b1001; t_a[6] = {16'd1, 16'd2, 16'd3}; t_b[6] = {16'd4, 16'd5, 16'd6};
        t_r[6] = '0; t_f[6] = 4'b0100;
        t_op[7] = 4'b1111; t_a[7] = t_a[6]; t_b[7] = t_b[6];
        t_r[7] = '0; t_f[7] = 4'b0100;

        // Reset state
        #2 reset = 1'b0;
        #1;
        expect_out("reset", '0, '0, 5'b00000, 1'b0, 4'b0000);
        check("reset.stall", 64'(stall), 64'(0));
        tick();
        tick();
        reset = 1'b1;

        issue(4'b0000, 1'b0, 1'b1, {16'd5, 16'hFFFF, 16'd1}, {16'd3, 16'd1, 16'd1},
              {16'd9, 16'd9, 16'd9}, 5'b10100);
        expect_out("add", {16'd8, 16'd0, 16'd2}, {16'd3, 16'd1, 16'd1}, 5'b10100, 1'b1, 4'b0000);

        issue(4'b0001, 1'b1, 1'b1, {16'd10, 16'd3, 16'h8000}, {16'd1, 16'd2, 16'd3},
              {16'd4, 16'd5, 16'd1}, 5'b01010);
        expect_out("sub_imm", {16'd6, 16'hFFFE, 16'h7FFF}, {16'd1, 16'd2, 16'd3}, 5'b01010, 1'b1, 4'b0011);

        valid_in = 1'b0;
        tick();
        expect_out("idle", {16'd6, 16'hFFFE, 16'h7FFF}, {16'd1, 16'd2, 16'd3}, 5'b01010, 1'b0, 4'b0011);

        issue(4'b0001, 1'b0, 1'b0, {16'd7, 16'd7, 16'h1234}, {16'd7, 16'd8, 16'h1234}, '0, 5'b00001);
        expect_out("sub_nofw", {16'd0, 16'hFFFF, 16'd0}, {16'd7, 16'd8, 16'h1234}, 5'b00001, 1'b1, 4'b0011);

        issue(4'b0001, 1'b0, 1'b1, {16'd0, 16'd0, 16'h55AA}, {16'd1, 16'd0, 16'h55AA}, '0, 5'b11111);
        expect_out("sub_zero", {16'hFFFF, 16'd0, 16'd0}, {16'd1, 16'd0, 16'h55AA}, 5'b11111, 1'b1, 4'b0110);

        issue(4'b0000, 1'b0, 1'b1, {16'd1, 16'd2, 16'h8000}, {16'd1, 16'd2, 16'h8000}, '0, 5'b00000);
        expect_out("add_zcv", {16'd2, 16'd4, 16'd0}, {16'd1, 16'd2, 16'h8000}, 5'b00000, 1'b1, 4'b0111);

        issue(4'b0000, 1'b1, 1'b1, {16'd0, 16'd0, 16'h7FFF}, {16'd5, 16'd5, 16'd5},
              {16'd0, 16'd0, 16'd1}, 5'b01000);
        expect_out("add_nv", {16'd0, 16'd0, 16'h8000}, {16'd5, 16'd5, 16'd5}, 5'b01000, 1'b1, 4'b1001);

        // Logic, shift, move and undefined ops, issued back to back
        for (int k = 0; k < 8; k++) begin
            logic        src;
            logic [47:0] b_reg;
            src   = (t_op[k] == 4'b1000);
            b_reg = src ? ~t_b[k] : t_b[k];
            issue(t_op[k], src, 1'b1, t_a[k], b_reg, t_b[k], 5'(k));
            expect_out($sformatf("op%0h", t_op[k]), t_r[k], b_reg, 5'(k), 1'b1, t_f[k]);
        end

        flush = 1'b1;
        issue(4'b0000, 1'b0, 1'b1, {16'd1, 16'd1, 16'd1}, {16'd1, 16'd1, 16'd1}, '0, 5'b11111);
        expect_out("flush_idle", '0, {16'd4, 16'd5, 16'd6}, 5'b00111, 1'b0, 4'b0100);
        flush = 1'b0;

`ifdef EXEC_MUL_EN
        issue(4'b0111, 1'b0, 1'b1, {16'd300, 16'd7, 16'hFFFF}, {16'd300, 16'd9, 16'd2}, '0, 5'b11010);
        check("mul.accept.valid", 64'(valid_out), 64'(0));
        check("mul.accept.stall", 64'(stall), 64'(1));
        alu_ctrl = 4'b0000; opa = '1; opb = '1; imm = '1; flag_write = 1'b0;
        {pc_src, reg_write, mem_to_reg, mem_write, branch} = 5'b00000;
        for (int k = 2; k <= 16; k++) begin
            tick();
            check($sformatf("mul.stall%0d", k), 64'(stall), 64'(1));
            check($sformatf("mul.valid%0d", k), 64'(valid_out), 64'(0));
        end
        valid_in = 1'b0;
        tick();
        expect_out("mul_done", {16'h5F90, 16'd63, 16'hFFFE}, {16'd300, 16'd9, 16'd2}, 5'b11010, 1'b1, 4'b1000);
        check("mul_done.stall", 64'(stall), 64'(0));

        issue(4'b0111, 1'b0, 1'b1, {16'd3, 16'd3, 16'd3}, {16'd3, 16'd3, 16'd3}, '0, 5'b00001);
        tick();
        tick();
        tick();
        flush = 1'b1;
        tick();
        expect_out("mul_flush", {16'h5F90, 16'd63, 16'hFFFE}, {16'd300, 16'd9, 16'd2}, 5'b11010, 1'b0, 4'b1000);
        check("mul_flush.stall", 64'(stall), 64'(0));
        flush = 1'b0;
        issue(4'b0000, 1'b0, 1'b1, {16'd1, 16'd2, 16'd3}, {16'd4, 16'd5, 16'd6}, '0, 5'b00011);
        expect_out("add_after_flush", {16'd5, 16'd7, 16'd9}, {16'd4, 16'd5, 16'd6}, 5'b00011, 1'b1, 4'b0000);
        check("add_after_flush.stall", 64'(stall), 64'(0));
`else
        issue(4'b0111, 1'b0, 1'b1, {16'd300, 16'd7, 16'hFFFF}, {16'd300, 16'd9, 16'd2}, '0, 5'b00110);
        expect_out("mul_undef", '0, {16'd300, 16'd9, 16'd2}, 5'b00110, 1'b1, 4'b0100);
        check("mul_undef.stall", 64'(stall), 64'(0));
        valid_in = 1'b0;
        tick();
        check("mul_undef.stall2", 64'(stall), 64'(0));
        check("mul_undef.valid2", 64'(valid_out), 64'(0));
`endif

        issue(4'b0000, 1'b0, 1'b1, {16'd1, 16'd2, 16'd3}, {16'd1, 16'd1, 16'd1}, '0, 5'b11111);
        expect_out("add_pre_rst", {16'd2, 16'd3, 16'd4}, {16'd1, 16'd1, 16'd1}, 5'b11111, 1'b1, 4'b0000);
`ifdef EXEC_MUL_EN
        issue(4'b0111, 1'b0, 1'b1, {16'd5, 16'd5, 16'd5}, {16'd5, 16'd5, 16'd5}, '0, 5'b10101);
        tick();
        tick();
        check("rst_mid.stall_before", 64'(stall), 64'(1));
`endif
        #2 reset = 1'b0;
        #1;
        expect_out("async_rst", '0, '0, 5'b00000, 1'b0, 4'b0000);
        check("async_rst.stall", 64'(stall), 64'(0));
        valid_in = 1'b0;
        tick();
        tick();
        reset = 1'b1;
        issue(4'b0000, 1'b0, 1'b1, {16'h0010, 16'h0020, 16'h0030}, {16'd1, 16'd2, 16'd3}, '0, 5'b01100);
        expect_out("add_post_rst", {16'h0011, 16'h0022, 16'h0033}, {16'd1, 16'd2, 16'd3}, 5'b01100, 1'b1, 4'b0000);
        check("add_post_rst.stall", 64'(stall), 64'(0));
        valid_in = 1'b0;

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
